// File: rtl/car_sequencer_if.sv
// Memory-side handshake between the microsequencer and the instruction/data memory.
// The sequencer is the requesting master; memory answers with read data and an ack.
interface car_sequencer_if;
  logic [15:0] fetch_word;
  logic        mem_ack;
  logic        mem_req;

  modport master (
    input  fetch_word,
    input  mem_ack,
    output mem_req
  );

  modport slave (
    output fetch_word,
    output mem_ack,
    input  mem_req
  );
endinterface

// File: rtl/car_sequencer.sv
// MSP430 microsequencer: steps each instruction (and interrupt entry) through its
// phases, publishing the phase code on CAR and the latched instruction on IR.
module car_sequencer #(
  parameter int CAR_BITS = 6
) (
  input  logic                MCLK,
  input  logic                RST_n,
  car_sequencer_if.master     memBus,
  input  logic                int_req,
  input  logic                GIE,
  input  logic                CPUOFF,
  output logic [CAR_BITS-1:0] CAR,
  output logic [15:0]         IR,
  output logic                INTACK,
  output logic                instr_done,
  output logic                illegal
);

  typedef enum logic [4:0] {
    RESET_VEC = 5'd0,
    FETCH     = 5'd1,
    SRC_EXT   = 5'd2,
    SRC_RD    = 5'd3,
    DST_EXT   = 5'd4,
    DST_RD    = 5'd5,
    EXEC      = 5'd6,
    DST_WR    = 5'd7,
    PUSH_WR   = 5'd8,
    CALL_WR   = 5'd9,
    RETI_SR   = 5'd10,
    RETI_PC   = 5'd11,
    JMP       = 5'd12,
    INT_PC    = 5'd13,
    INT_SR    = 5'd14,
    INT_VEC   = 5'd15,
    IDLE      = 5'd16
  } seqState_t;

  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RETI = 3'd6;
  localparam logic [2:0] OP_BAD  = 3'd7;

  seqState_t state;
  seqState_t stateNext;

  logic [8:0] decHi;
  logic [5:0] decLo;
  logic [3:0] opcode;
  logic [2:0] fmtIIop;
  logic [3:0] srcReg;
  logic [1:0] srcMode;
  logic       isFmtI;
  logic       isFmtII;
  logic       isJump;
  logic       isIllegal;
  logic       dstIndexed;
  logic       isMov;
  logic       constGen;
  logic       srcExt;
  logic       srcRd;
  logic       dstWr;
  logic       memState;
  logic       wantInt;

  logic       doneNow;
  logic       ackNow;
  logic       illegalNow;
  seqState_t  afterSrc;
  seqState_t  firstPhase;
  seqState_t  endState;

  // During FETCH the word on the bus is decoded so the first phase can be chosen on the ack
  // cycle; every later phase decodes the latched IR. Bit 6 (byte/word) never steers sequencing.
  always_comb begin
    decHi = (state == FETCH) ? memBus.fetch_word[15:7] : IR[15:7];
    decLo = (state == FETCH) ? memBus.fetch_word[5:0]  : IR[5:0];
  end

  assign opcode     = decHi[8:5];
  assign fmtIIop    = decHi[2:0];
  assign dstIndexed = decHi[0];
  assign srcMode    = decLo[5:4];

  assign isFmtI    = (decHi[8:7] != 2'b00);
  assign isFmtII   = (decHi[8:3] == 6'b000100);
  assign isJump    = (decHi[8:6] == 3'b001);
  assign isIllegal = !(isFmtI || isFmtII || isJump) || (isFmtII && fmtIIop == OP_BAD);
  assign isMov     = (opcode == 4'd4);

  assign srcReg = isFmtI ? decHi[4:1] : decLo[3:0];

  // R3 always generates constants; R2 does so in the indirect modes.
  assign constGen = (srcReg == 4'd3) || (srcReg == 4'd2 && srcMode[1]);

  assign srcExt = (srcMode == 2'b01 && srcReg != 4'd3) ||
                  (srcMode == 2'b11 && srcReg == 4'd0);
  assign srcRd  = (srcMode == 2'b01 && srcReg != 4'd3) ||
                  (srcMode[1] && srcReg != 4'd0 && srcReg != 4'd2 && srcReg != 4'd3);
  assign dstWr  = isFmtI ? dstIndexed : (srcMode != 2'b00 && !constGen);

  assign memState = !(state == EXEC || state == JMP || state == IDLE);
  assign wantInt  = int_req && GIE;

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= RESET_VEC;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      IR <= 16'h0000;
    end else if (state == FETCH && memBus.mem_ack) begin
      IR <= memBus.fetch_word;
    end
  end

  // Memory phases hold until acked; every other phase lasts one cycle. Instruction-end
  // decisions for memory phases are taken on their ack cycle.
  always_comb begin
    stateNext  = state;
    doneNow    = 1'b0;
    ackNow     = 1'b0;
    illegalNow = 1'b0;
    afterSrc   = EXEC;
    firstPhase = EXEC;
    endState   = FETCH;

    if (isFmtI) begin
      afterSrc = dstIndexed ? DST_EXT : EXEC;
    end else if (fmtIIop == OP_PUSH) begin
      afterSrc = PUSH_WR;
    end else if (fmtIIop == OP_CALL) begin
      afterSrc = CALL_WR;
    end

    if (srcExt) begin
      firstPhase = SRC_EXT;
    end else if (srcRd) begin
      firstPhase = SRC_RD;
    end else begin
      firstPhase = afterSrc;
    end

    if (wantInt) begin
      endState = INT_PC;
    end else if (CPUOFF) begin
      endState = IDLE;
    end

    case (state)
      RESET_VEC: if (memBus.mem_ack) stateNext = FETCH;
      FETCH: begin
        if (memBus.mem_ack) begin
          if (isIllegal) begin
            illegalNow = 1'b1;
            doneNow    = 1'b1;
            stateNext  = endState;
          end else if (isJump) begin
            stateNext = JMP;
          end else if (isFmtII && fmtIIop == OP_RETI) begin
            stateNext = RETI_SR;
          end else begin
            stateNext = firstPhase;
          end
        end
      end
      SRC_EXT: if (memBus.mem_ack) stateNext = srcRd ? SRC_RD : afterSrc;
      SRC_RD:  if (memBus.mem_ack) stateNext = afterSrc;
      DST_EXT: if (memBus.mem_ack) stateNext = isMov ? EXEC : DST_RD;
      DST_RD:  if (memBus.mem_ack) stateNext = EXEC;
      EXEC: begin
        if (dstWr) begin
          stateNext = DST_WR;
        end else begin
          doneNow   = 1'b1;
          stateNext = endState;
        end
      end
      DST_WR, PUSH_WR, CALL_WR, RETI_PC: begin
        if (memBus.mem_ack) begin
          doneNow   = 1'b1;
          stateNext = endState;
        end
      end
      RETI_SR: if (memBus.mem_ack) stateNext = RETI_PC;
      JMP: begin
        doneNow   = 1'b1;
        stateNext = endState;
      end
      INT_PC: if (memBus.mem_ack) stateNext = INT_SR;
      INT_SR: if (memBus.mem_ack) stateNext = INT_VEC;
      INT_VEC: begin
        // The ISR always runs, so CPUOFF is not consulted here.
        if (memBus.mem_ack) begin
          doneNow   = 1'b1;
          ackNow    = 1'b1;
          stateNext = FETCH;
        end
      end
      IDLE:    if (wantInt) stateNext = INT_PC;
      default: stateNext = RESET_VEC;
    endcase
  end

  // Reset gates the request so an in-flight access is dropped the moment RST_n falls.
  assign memBus.mem_req = RST_n && memState;
  assign CAR            = CAR_BITS'(state);
  assign instr_done     = doneNow;
  assign INTACK         = ackNow;
  assign illegal        = illegalNow;

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: table of instruction traces plus hand-written
// sequences for reset, CPUOFF sleep/wake and reset aborting an access.
module tb_car_sequencer;

  logic        MCLK = 1'b0;
  logic        RST_n;
  logic        int_req;
  logic        GIE;
  logic        CPUOFF;
  logic [5:0]  CAR;
  logic [15:0] IR;
  logic        INTACK;
  logic        instr_done;
  logic        illegal;

  int errCount   = 0;
  int checkCount = 0;

  car_sequencer_if memBus ();

  car_sequencer #(.CAR_BITS(6)) dut (
    .MCLK       (MCLK),
    .RST_n      (RST_n),
    .memBus     (memBus),
    .int_req    (int_req),
    .GIE        (GIE),
    .CPUOFF     (CPUOFF),
    .CAR        (CAR),
    .IR         (IR),
    .INTACK     (INTACK),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 MCLK = ~MCLK;

  // One record per instruction: seq holds one CAR code per byte, index 0 in the low byte;
  // masks flag which trace index pulses instr_done / INTACK / illegal.
  typedef struct {
    logic [15:0] word;
    logic        intReq;
    logic        gie;
    logic        cpuoff;
    int          waits;
    int          len;
    logic [63:0] seq;
    logic [7:0]  doneMask;
    logic [7:0]  ackMask;
    logic [7:0]  illMask;
    logic [5:0]  nextCar;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  task automatic applyStimulus(input logic [15:0] word, input logic ack);
    memBus.fetch_word = word;
    memBus.mem_ack    = ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  function automatic logic isMem(input logic [5:0] s);
    return !(s == 6'd6 || s == 6'd12 || s == 6'd16);
  endfunction

  initial begin
    tbl[0]  = '{16'h4A0B, 1'b0, 1'b0, 1'b0, 0, 2, 64'h0601,             8'h02, 8'h00, 8'h00, 6'd1};
    tbl[1]  = '{16'h5596, 1'b0, 1'b0, 1'b0, 0, 7, 64'h07060504030201,   8'h40, 8'h00, 8'h00, 6'd1};
    tbl[2]  = '{16'h5596, 1'b0, 1'b0, 1'b0, 2, 7, 64'h07060504030201,   8'h40, 8'h00, 8'h00, 6'd1};
    tbl[3]  = '{16'h40B2, 1'b0, 1'b0, 1'b0, 0, 5, 64'h0706040201,       8'h10, 8'h00, 8'h00, 6'd1};
    tbl[4]  = '{16'h3C00, 1'b0, 1'b0, 1'b0, 0, 2, 64'h0C01,             8'h02, 8'h00, 8'h00, 6'd1};
    tbl[5]  = '{16'h1205, 1'b0, 1'b0, 1'b0, 0, 2, 64'h0801,             8'h02, 8'h00, 8'h00, 6'd1};
    tbl[6]  = '{16'h12B0, 1'b0, 1'b0, 1'b0, 0, 3, 64'h090201,           8'h04, 8'h00, 8'h00, 6'd1};
    tbl[7]  = '{16'h1024, 1'b0, 1'b0, 1'b0, 0, 4, 64'h07060301,         8'h08, 8'h00, 8'h00, 6'd1};
    tbl[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 0, 1, 64'h01,               8'h01, 8'h00, 8'h01, 6'd1};
    tbl[9]  = '{16'h1380, 1'b0, 1'b0, 1'b0, 0, 1, 64'h01,               8'h01, 8'h00, 8'h01, 6'd1};
    tbl[10] = '{16'h4A0B, 1'b1, 1'b0, 1'b0, 0, 2, 64'h0601,             8'h02, 8'h00, 8'h00, 6'd1};
    tbl[11] = '{16'h1300, 1'b1, 1'b1, 1'b0, 1, 6, 64'h0F0E0D0B0A01,     8'h24, 8'h20, 8'h00, 6'd1};
    tbl[12] = '{16'h4A0B, 1'b0, 1'b0, 1'b1, 0, 2, 64'h0601,             8'h02, 8'h00, 8'h00, 6'd16};

    int_req = 1'b0;
    GIE     = 1'b0;
    CPUOFF  = 1'b0;
    RST_n   = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    #3;
    checkOutput("reset CAR", CAR, 0);
    checkOutput("reset mem_req", memBus.mem_req, 0);
    checkOutput("reset IR", IR, 0);
    checkOutput("reset pulses", {INTACK, instr_done, illegal}, 0);

    // Reset release with two wait cycles on the reset-vector read.
    @(posedge MCLK);
    #1;
    RST_n = 1'b1;
    for (int w = 0; w < 3; w++) begin
      applyStimulus(16'h0000, w == 2);
      #1;
      checkOutput("resetvec CAR", CAR, 0);
      checkOutput("resetvec mem_req", memBus.mem_req, 1);
      step();
    end
    checkOutput("after resetvec CAR", CAR, 1);

    for (int v = 0; v < NVEC; v++) begin
      int_req = tbl[v].intReq;
      GIE     = tbl[v].gie;
      CPUOFF  = tbl[v].cpuoff;
      for (int i = 0; i < tbl[v].len; i++) begin
        logic [5:0]  cur;
        logic [15:0] drive;
        cur   = {1'b0, tbl[v].seq[i*8 +: 5]};
        drive = (cur == 6'd1) ? tbl[v].word : 16'hDEAD;
        if (isMem(cur)) begin
          for (int w = 0; w < tbl[v].waits; w++) begin
            applyStimulus(drive, 1'b0);
            #1;
            checkOutput($sformatf("v%0d wait CAR", v), CAR, cur);
            checkOutput($sformatf("v%0d wait done", v), instr_done, 0);
            step();
          end
        end
        applyStimulus(drive, 1'b1);
        #1;
        checkOutput($sformatf("v%0d[%0d] CAR", v, i), CAR, cur);
        checkOutput($sformatf("v%0d[%0d] mem_req", v, i), memBus.mem_req, isMem(cur));
        checkOutput($sformatf("v%0d[%0d] instr_done", v, i), instr_done, tbl[v].doneMask[i]);
        checkOutput($sformatf("v%0d[%0d] INTACK", v, i), INTACK, tbl[v].ackMask[i]);
        checkOutput($sformatf("v%0d[%0d] illegal", v, i), illegal, tbl[v].illMask[i]);
        step();
      end
      checkOutput($sformatf("v%0d next CAR", v), CAR, tbl[v].nextCar);
      checkOutput($sformatf("v%0d IR", v), IR, tbl[v].word);
    end

    // Sleeping in IDLE: masked interrupt and CPUOFF dropping must not wake; GIE does.
    int_req = 1'b1;
    GIE     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      CPUOFF = (c < 2);
      applyStimulus(16'hDEAD, 1'b1);
      #1;
      checkOutput("idle CAR", CAR, 16);
      checkOutput("idle mem_req", memBus.mem_req, 0);
      checkOutput("idle done", instr_done, 0);
      step();
    end
    GIE = 1'b1;
    #1;
    checkOutput("idle still before edge", CAR, 16);
    step();
    for (int s = 13; s <= 15; s++) begin
      applyStimulus(16'hDEAD, 1'b1);
      #1;
      checkOutput("wake CAR", CAR, s);
      checkOutput("wake INTACK", INTACK, s == 15);
      checkOutput("wake done", instr_done, s == 15);
      step();
    end
    checkOutput("wake then fetch", CAR, 1);
    checkOutput("IR held across int entry", IR, 16'h4A0B);
    int_req = 1'b0;
    GIE     = 1'b0;

    // Reset asserted while SRC_RD is waiting on memory.
    applyStimulus(16'h5596, 1'b1);
    step();
    checkOutput("abort SRC_EXT", CAR, 2);
    applyStimulus(16'hDEAD, 1'b1);
    step();
    applyStimulus(16'hDEAD, 1'b0);
    #1;
    checkOutput("abort SRC_RD", CAR, 3);
    checkOutput("abort IR before", IR, 16'h5596);
    RST_n = 1'b0;
    applyStimulus(16'hDEAD, 1'b1);
    #1;
    checkOutput("abort CAR", CAR, 0);
    checkOutput("abort mem_req", memBus.mem_req, 0);
    checkOutput("abort IR", IR, 0);
    checkOutput("abort pulses", {INTACK, instr_done, illegal}, 0);
    step();
    checkOutput("abort held CAR", CAR, 0);
    RST_n = 1'b1;
    #1;
    checkOutput("abort release mem_req", memBus.mem_req, 1);
    step();
    checkOutput("abort release CAR", CAR, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
